mdr_seq_unit: RTL and testbench
===============================

# mdr_seq_unit

Parametrised, iterative signed multiply / divide / square-root engine: the next-generation sequential datapath of the MDR system. It accepts one operation at a time through a start/ready handshake, validates operands, runs a shift-add (radix-2 Booth), non-restoring divide or non-restoring square-root loop for a width-dependent number of cycles, then presents result, remainder, error and overflow with a one-cycle done pulse. It replaces the fixed-width control/ALU/validation path with a single width-generic block driven by the system controller.

## Interface
- DW, 16: operand/result width in bits; even, 4..64.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request; accepted only when ready=1.
- op  in  2  operation: 00 MUL, 01 DIV, 10 SQRT, 11 reserved.
- data_x  in  DW  signed operand X (multiplicand / dividend / radicand).
- data_y  in  DW  signed operand Y (multiplier / divisor; ignored for SQRT).
- ready  out  1  block idle, start will be accepted.
- done  out  1  one-cycle pulse, outputs valid from this cycle.
- result  out  DW  product low half / quotient / root.
- remainder  out  DW  product high half / remainder / radicand − root².
- error  out  1  invalid operation (DIV by zero, SQRT of negative, op=11).
- ovf  out  1  result not representable in DW signed bits.

## Operation
- States: IDLE, CHECK, RUN, FIX, DONE.
- IDLE: ready=1. start=1 captures op, data_x, data_y into internal registers; next state CHECK. ready=0 in every other state.
- CHECK (1 cycle): error condition → DONE with result=0, remainder=0, error=1, ovf=0. Otherwise load iteration counter with N and go RUN. N = DW for MUL/DIV, DW/2 for SQRT.
- RUN (N cycles): one iteration per cycle; counter decrements; last iteration → FIX.
  - MUL: radix-2 Booth on {acc, Y, q−1}, 2·DW+1 bit, arithmetic right shift each step.
  - DIV: non-restoring on magnitudes |X|, |Y|; final remainder restore in FIX.
  - SQRT: non-restoring, two radicand bits per iteration, X treated as unsigned after CHECK.
- FIX (1 cycle): DIV sign correction (quotient negative iff signs differ; remainder takes sign of dividend; truncation toward zero); remainder restore; overflow evaluation. Registers result/remainder/error/ovf.
- DONE (1 cycle): done=1; next state IDLE.
- MUL ovf=1 iff high half is not the sign extension of result[DW−1]. DIV ovf=1 only for X=−2^(DW−1), Y=−1: result=0x8000 pattern, remainder=0. SQRT ovf always 0.
- Outputs result, remainder, error, ovf hold their last value until the next FIX/CHECK update; inputs may change freely after acceptance.
- start while ready=0: ignored, no effect on the running operation.

## Timing
- Reset: state IDLE, ready=1, done=0, result=0, remainder=0, error=0, ovf=0, counter=0. rst asserted mid-operation aborts immediately; no done pulse is produced for the aborted request.
- Latency: start sampled at edge k → done high in cycle k+N+3 (CHECK, N×RUN, FIX, DONE). MUL/DIV: DW+3; SQRT: DW/2+3. Error path: done high in cycle k+2.
- ready returns to 1 the cycle after done; throughput is one operation per latency+1 cycles.
- done and updated outputs are visible in the same cycle.

## Test plan
- DW=16, MUL X=7, Y=−3 → result=0xFFEB, remainder=0xFFFF, ovf=0, error=0, done 19 cycles after start.
- MUL X=300, Y=300 → result=0x5F90, remainder=0x0001, ovf=1; MUL X=−32768, Y=−32768 → result=0x0000, remainder=0x4000, ovf=1.
- DIV X=−7, Y=2 → result=0xFFFD, remainder=0xFFFF; DIV X=100, Y=0 → error=1, result=0, remainder=0, done 2 cycles after start.
- DIV X=−32768, Y=−1 → result=0x8000, remainder=0, ovf=1; op=11 → error=1.
- SQRT X=1000 → result=31, remainder=39, done 11 cycles after start; SQRT X=−4 → error=1; SQRT X=0x7FFF → result=181, remainder=6.
- Start MUL, pulse start with new operands during RUN → ignored, original result returned; assert rst during RUN cycle 5 → all outputs 0, ready=1 next cycle, no done; fresh DIV then completes correctly.

Source files
------------

// File: rtl/mdr_seq_unit.sv
// Iterative signed multiply / divide / square-root engine with start/ready handshake.
// One iteration per cycle: radix-2 Booth MUL, non-restoring DIV and SQRT.
module mdr_seq_unit #(
  parameter int DW = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [1:0]    op_i,
  input  logic [DW-1:0] data_x_i,
  input  logic [DW-1:0] data_y_i,
  output logic          ready_o,
  output logic          done_o,
  output logic [DW-1:0] result_o,
  output logic [DW-1:0] remainder_o,
  output logic          error_o,
  output logic          ovf_o
);

  localparam int RW = DW + 2;
  localparam int CW = $clog2(DW + 1);
  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_SQRT = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_RUN, S_FIX, S_DONE} state_t;

  state_t          state_q;
  logic [1:0]      op_q;
  logic [DW-1:0]   x_q, y_q, d_q, mq_q;
  logic [RW-1:0]   acc_q;
  logic            qm1_q;
  logic [CW-1:0]   cnt_q;
  logic            ready_q, done_q, error_q, ovf_q;
  logic [DW-1:0]   result_q, remn_q;

  logic [RW-1:0]   acc_d, sum, shl;
  logic [DW-1:0]   mq_d, x_d, x_abs, y_abs;
  logic            qm1_d, err_c;
  logic [DW-1:0]   fix_res, fix_rem, r_low;
  logic            fix_ovf;

  always_comb begin
    x_abs = x_q[DW-1] ? (~x_q + DW'(1)) : x_q;
    y_abs = y_q[DW-1] ? (~y_q + DW'(1)) : y_q;
    err_c = (op_q == 2'b11) || (op_q == OP_DIV && y_q == '0) ||
            (op_q == OP_SQRT && x_q[DW-1]);
  end

  always_comb begin
    acc_d = acc_q;
    mq_d  = mq_q;
    qm1_d = qm1_q;
    x_d   = x_q;
    sum   = acc_q;
    shl   = acc_q;
    case (op_q)
      OP_MUL: begin
        case ({mq_q[0], qm1_q})
          2'b01:   sum = acc_q + {{2{x_q[DW-1]}}, x_q};
          2'b10:   sum = acc_q - {{2{x_q[DW-1]}}, x_q};
          default: sum = acc_q;
        endcase
        acc_d = {sum[RW-1], sum[RW-1:1]};
        mq_d  = {sum[0], mq_q[DW-1:1]};
        qm1_d = mq_q[0];
      end
      OP_DIV: begin
        shl   = {acc_q[RW-2:0], mq_q[DW-1]};
        sum   = acc_q[RW-1] ? (shl + {2'b00, d_q}) : (shl - {2'b00, d_q});
        acc_d = sum;
        mq_d  = {mq_q[DW-2:0], ~sum[RW-1]};
      end
      OP_SQRT: begin
        // radicand pairs are consumed from the top of x_q, root grows in mq_q
        shl   = {acc_q[RW-3:0], x_q[DW-1:DW-2]};
        sum   = acc_q[RW-1] ? (shl + {mq_q, 2'b11}) : (shl - {mq_q, 2'b01});
        acc_d = sum;
        mq_d  = {mq_q[DW-2:0], ~sum[RW-1]};
        x_d   = {x_q[DW-3:0], 2'b00};
      end
      default: ;
    endcase
  end

  always_comb begin
    fix_res = mq_q;
    fix_rem = acc_q[DW-1:0];
    fix_ovf = 1'b0;
    r_low   = acc_q[DW-1:0];
    case (op_q)
      OP_MUL: fix_ovf = (acc_q[DW-1:0] != {DW{mq_q[DW-1]}});
      OP_DIV: begin
        r_low   = acc_q[RW-1] ? (acc_q[DW-1:0] + d_q) : acc_q[DW-1:0];
        fix_res = (x_q[DW-1] ^ y_q[DW-1]) ? (~mq_q + DW'(1)) : mq_q;
        fix_rem = x_q[DW-1] ? (~r_low + DW'(1)) : r_low;
        fix_ovf = (x_q == {1'b1, {(DW-1){1'b0}}}) && (y_q == '1);
      end
      OP_SQRT: begin
        r_low   = acc_q[RW-1] ? (acc_q[DW-1:0] + {mq_q[DW-2:0], 1'b1}) : acc_q[DW-1:0];
        fix_rem = r_low;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      d_q      <= '0;
      mq_q     <= '0;
      acc_q    <= '0;
      qm1_q    <= 1'b0;
      cnt_q    <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      remn_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start_i) begin
          op_q    <= op_i;
          x_q     <= data_x_i;
          y_q     <= data_y_i;
          ready_q <= 1'b0;
          state_q <= S_CHECK;
        end
        S_CHECK: if (err_c) begin
          result_q <= '0;
          remn_q   <= '0;
          error_q  <= 1'b1;
          ovf_q    <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= S_DONE;
        end else begin
          cnt_q   <= (op_q == OP_SQRT) ? CW'(DW / 2) : CW'(DW);
          acc_q   <= '0;
          qm1_q   <= 1'b0;
          mq_q    <= (op_q == OP_MUL) ? y_q : (op_q == OP_DIV) ? x_abs : '0;
          d_q     <= y_abs;
          state_q <= S_RUN;
        end
        S_RUN: begin
          acc_q <= acc_d;
          mq_q  <= mq_d;
          qm1_q <= qm1_d;
          x_q   <= x_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= S_FIX;
        end
        S_FIX: begin
          result_q <= fix_res;
          remn_q   <= fix_rem;
          error_q  <= 1'b0;
          ovf_q    <= fix_ovf;
          done_q   <= 1'b1;
          state_q  <= S_DONE;
        end
        S_DONE: begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ready_o     = ready_q;
  assign done_o      = done_q;
  assign result_o    = result_q;
  assign remainder_o = remn_q;
  assign error_o     = error_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_mdr_seq_unit.sv
// Directed bench for mdr_seq_unit (DW=16): vector table plus abort/ignored-start sequences.
module tb_mdr_seq_unit;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    op;
  logic [DW-1:0] data_x, data_y;
  logic          ready, done, error, ovf;
  logic [DW-1:0] result, remainder;

  int total = 0;
  int bad   = 0;

  mdr_seq_unit #(.DW(DW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op),
    .data_x_i(data_x), .data_y_i(data_y),
    .ready_o(ready), .done_o(done), .result_o(result),
    .remainder_o(remainder), .error_o(error), .ovf_o(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    op;
    logic [DW-1:0] x, y, res, rem;
    logic          err, ovf;
    int            lat;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [DW-1:0] x, input logic [DW-1:0] y,
                        output int lat, output logic rdy1);
    @(negedge clk);
    op = o; data_x = x; data_y = y; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    data_x = ~x; data_y = ~y;
    lat = 0; rdy1 = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) rdy1 = ready;
    end while (!done && lat < 100);
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    int   lat;
    logic rdy1;
    run_op(v.op, v.x, v.y, lat, rdy1);
    chk({tag, " latency"}, lat, v.lat);
    chk({tag, " busy"}, {31'd0, rdy1}, 32'd0);
    chk({tag, " result"}, {16'd0, result}, {16'd0, v.res});
    chk({tag, " remainder"}, {16'd0, remainder}, {16'd0, v.rem});
    chk({tag, " error"}, {31'd0, error}, {31'd0, v.err});
    chk({tag, " ovf"}, {31'd0, ovf}, {31'd0, v.ovf});
    @(negedge clk);
    chk({tag, " ready after"}, {30'd0, ready, done}, 32'd2);
  endtask

  initial begin
    int   lat;
    int   ndone;
    vecs[0]  = '{2'b00, 16'h0007, 16'hFFFD, 16'hFFEB, 16'hFFFF, 1'b0, 1'b0, 19};
    vecs[1]  = '{2'b00, 16'd300,  16'd300,  16'h5F90, 16'h0001, 1'b0, 1'b1, 19};
    vecs[2]  = '{2'b00, 16'h8000, 16'h8000, 16'h0000, 16'h4000, 1'b0, 1'b1, 19};
    vecs[3]  = '{2'b00, 16'hFFFB, 16'hFFFA, 16'h001E, 16'h0000, 1'b0, 1'b0, 19};
    vecs[4]  = '{2'b00, 16'h7FFF, 16'h7FFF, 16'h0001, 16'h3FFF, 1'b0, 1'b1, 19};
    vecs[5]  = '{2'b00, 16'hFFFF, 16'h0001, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 19};
    vecs[6]  = '{2'b01, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0, 19};
    vecs[7]  = '{2'b01, 16'd100,  16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 2};
    vecs[8]  = '{2'b01, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 1'b1, 19};
    vecs[9]  = '{2'b11, 16'h0005, 16'h0003, 16'h0000, 16'h0000, 1'b1, 1'b0, 2};
    vecs[10] = '{2'b10, 16'd1000, 16'h0000, 16'd31,   16'd39,   1'b0, 1'b0, 11};
    vecs[11] = '{2'b10, 16'hFFFC, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 2};
    vecs[12] = '{2'b10, 16'h7FFF, 16'h0000, 16'd181,  16'd6,    1'b0, 1'b0, 11};
    vecs[13] = '{2'b01, 16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0, 1'b0, 19};
    vecs[14] = '{2'b01, 16'd100,  16'd7,    16'd14,   16'd2,    1'b0, 1'b0, 19};
    vecs[15] = '{2'b10, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 1'b0, 1'b0, 11};
    vecs[16] = '{2'b01, 16'h8000, 16'h0001, 16'h8000, 16'h0000, 1'b0, 1'b0, 19};

    rst = 1'b1; start = 1'b0; op = 2'b00; data_x = '0; data_y = '0;
    #12;
    chk("reset ready/done", {30'd0, ready, done}, 32'd2);
    chk("reset result", {16'd0, result}, 32'd0);
    chk("reset remainder", {16'd0, remainder}, 32'd0);
    chk("reset err/ovf", {30'd0, error, ovf}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) check_vec($sformatf("v%0d", i), vecs[i]);

    // start pulse with different operands while busy must be ignored
    @(negedge clk);
    op = 2'b00; data_x = 16'd7; data_y = 16'hFFFD; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (done) break;
      if (lat == 5) begin op = 2'b01; data_x = 16'd100; data_y = 16'd7; start = 1'b1; end
      else start = 1'b0;
    end while (lat < 100);
    start = 1'b0;
    chk("busy start latency", lat, 19);
    chk("busy start result", {16'd0, result}, 32'h0000FFEB);
    chk("busy start remainder", {16'd0, remainder}, 32'h0000FFFF);
    @(negedge clk);

    // reset during the fifth RUN cycle aborts without a done pulse
    @(negedge clk);
    op = 2'b00; data_x = 16'd300; data_y = 16'd300; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    ndone = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    rst = 1'b1;
    #1;
    chk("abort result", {16'd0, result}, 32'd0);
    chk("abort remainder", {16'd0, remainder}, 32'd0);
    chk("abort err/ovf/done", {29'd0, error, ovf, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("abort ready", {31'd0, ready}, 32'd1);
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort no done", ndone, 0);
    check_vec("post-abort div", vecs[14]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
